// File: rtl/hls_deadlock_monitor_gen.sv
`default_nettype none
// ============================================================================
// hls_deadlock_monitor_gen : parametrised dataflow-region deadlock monitor
// Revision 1.0
// ============================================================================
module hls_deadlock_monitor_gen #(
  parameter int                           NUM_PROC  = 5,
  parameter int                           NUM_AXIS  = 3,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP  = '0,
  parameter int                           CNT_W     = 8,
  parameter int                           THRESHOLD = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_PROC-1:0] sub_block,
  input  logic                clear,
  output logic                block,
  output logic                block_sticky,
  output logic [NUM_PROC-1:0] block_proc_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_PROC-1:0] axis_blk;
  logic [NUM_PROC-1:0] stop;
  logic                cond;
  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt, next_cnt;
  logic                enter_blocked;

  // A process whose map slice is all-zero can never be AXIS-blocked.
  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    assign axis_blk[i] = sub_block[i] &
                         (|(axis_block_sigs & AXIS_MAP[i*NUM_AXIS +: NUM_AXIS]));
  end

  assign stop = inst_idle_sigs | inst_block_sigs | axis_blk;
  assign cond = (|axis_blk) & (&stop);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        next_cnt = '0;
        if (cond) begin
          if (THRESHOLD == 1) begin
            next_state = BLOCKED;
          end else begin
            next_state = ARMED;
            next_cnt   = CNT_W'(1);
          end
        end
      end
      ARMED: begin
        if (!cond) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt == THR_LAST) begin
          next_state = BLOCKED;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (!cond) begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign enter_blocked = (next_state == BLOCKED) && (state != BLOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Set/load take priority over clear so a deadlock event is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      block          <= 1'b0;
      block_sticky   <= 1'b0;
      block_proc_vec <= '0;
      stall_cnt      <= '0;
    end else begin
      block <= (next_state == BLOCKED);

      if (next_state == BLOCKED)
        block_sticky <= 1'b1;
      else if (clear)
        block_sticky <= 1'b0;

      if (enter_blocked)
        block_proc_vec <= axis_blk;
      else if (clear)
        block_proc_vec <= '0;

      if (!cond)
        stall_cnt <= '0;
      else if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hls_deadlock_monitor_gen.sv
`default_nettype none
// ============================================================================
// tb_hls_deadlock_monitor_gen : directed bench over three parameterisations
// Revision 1.0
// ============================================================================
module tb_hls_deadlock_monitor_gen;

  localparam logic [14:0] MAP = 15'h0C01; // AXIS0->proc0, AXIS1/2->proc3

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] axis  = '0;
  logic [4:0] idle  = '0;
  logic [4:0] chblk = '0;
  logic [4:0] sub   = 5'b11111;
  logic       clear = 1'b0;

  logic       blk1, stk1, blk4, stk4, blk3, stk3;
  logic [4:0] vec1, vec4, vec3;
  logic [7:0] sc1, sc4;
  logic [2:0] sc3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hls_deadlock_monitor_gen #(.NUM_PROC(5), .NUM_AXIS(3), .AXIS_MAP(MAP),
                             .CNT_W(8), .THRESHOLD(1)) dut1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chblk), .sub_block(sub), .clear(clear), .block(blk1),
    .block_sticky(stk1), .block_proc_vec(vec1), .stall_cnt(sc1));

  hls_deadlock_monitor_gen #(.NUM_PROC(5), .NUM_AXIS(3), .AXIS_MAP(MAP),
                             .CNT_W(8), .THRESHOLD(4)) dut4 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chblk), .sub_block(sub), .clear(clear), .block(blk4),
    .block_sticky(stk4), .block_proc_vec(vec4), .stall_cnt(sc4));

  hls_deadlock_monitor_gen #(.NUM_PROC(5), .NUM_AXIS(3), .AXIS_MAP(MAP),
                             .CNT_W(3), .THRESHOLD(1)) dut3 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(chblk), .sub_block(sub), .clear(clear), .block(blk3),
    .block_sticky(stk3), .block_proc_vec(vec3), .stall_cnt(sc3));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    axis = '0; idle = '0; chblk = '0; sub = 5'b11111; clear = 1'b0;
  endtask

  task automatic deadlock_inputs();
    idle = 5'b11110; chblk = '0; axis = 3'b001; sub = 5'b11111;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    deadlock_inputs();
    clear = 1'b0;
    reset = 1'b1;
    step(); step();
    total++; if (blk1 !== 1'b0) begin bad++; $display("FAIL reset_block got=%b want=0", blk1); end
    total++; if (stk1 !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", stk1); end
    total++; if (vec1 !== 5'b0) begin bad++; $display("FAIL reset_vec got=%b want=00000", vec1); end
    total++; if (sc1 !== 8'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", sc1); end
    reset = 1'b0;
    quiet();
    step();
  endtask

  task automatic test_basic();
    do_reset();
    deadlock_inputs();
    step();
    total++; if (blk1 !== 1'b1) begin bad++; $display("FAIL basic_block got=%b want=1", blk1); end
    total++; if (vec1 !== 5'b00001) begin bad++; $display("FAIL basic_vec got=%b want=00001", vec1); end
    total++; if (stk1 !== 1'b1) begin bad++; $display("FAIL basic_sticky got=%b want=1", stk1); end
    total++; if (sc1 !== 8'd1) begin bad++; $display("FAIL basic_stall got=%0d want=1", sc1); end
    total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL basic_thr4_early got=%b want=0", blk4); end
    quiet();
    step();
    total++; if (blk1 !== 1'b0) begin bad++; $display("FAIL basic_fall got=%b want=0", blk1); end
    total++; if (stk1 !== 1'b1) begin bad++; $display("FAIL basic_sticky_hold got=%b want=1", stk1); end
    total++; if (sc1 !== 8'd0) begin bad++; $display("FAIL basic_stall_zero got=%0d want=0", sc1); end
  endtask

  task automatic test_no_axis();
    do_reset();
    chblk = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (blk1 !== 1'b0) begin bad++; $display("FAIL noaxis_block got=%b want=0", blk1); end
      total++; if (sc1 !== 8'd0) begin bad++; $display("FAIL noaxis_stall got=%0d want=0", sc1); end
    end
  endtask

  task automatic test_threshold();
    do_reset();
    deadlock_inputs();
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL thr_short_block cyc=%0d got=%b want=0", k, blk4); end
    end
    quiet();
    step();
    total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL thr_drop_block got=%b want=0", blk4); end
    deadlock_inputs();
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL thr_arm_block cyc=%0d got=%b want=0", k, blk4); end
    end
    step();
    total++; if (blk4 !== 1'b1) begin bad++; $display("FAIL thr_block got=%b want=1", blk4); end
    total++; if (sc4 !== 8'd4) begin bad++; $display("FAIL thr_stall got=%0d want=4", sc4); end
    total++; if (vec4 !== 5'b00001) begin bad++; $display("FAIL thr_vec got=%b want=00001", vec4); end
    quiet();
    step();
    total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL thr_fall got=%b want=0", blk4); end
  endtask

  task automatic test_sub_gating();
    do_reset();
    sub = 5'b10111; axis = 3'b110; idle = 5'b10111; chblk = '0;
    step(); step();
    total++; if (blk1 !== 1'b0) begin bad++; $display("FAIL sub_gated_block got=%b want=0", blk1); end
    total++; if (sc1 !== 8'd0) begin bad++; $display("FAIL sub_gated_stall got=%0d want=0", sc1); end
    sub = 5'b11111;
    step();
    total++; if (blk1 !== 1'b1) begin bad++; $display("FAIL sub_open_block got=%b want=1", blk1); end
    total++; if (vec1 !== 5'b01000) begin bad++; $display("FAIL sub_open_vec got=%b want=01000", vec1); end
    step(); step();
    total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL sub_thr4_early got=%b want=0", blk4); end
    step();
    total++; if (blk4 !== 1'b1) begin bad++; $display("FAIL sub_thr4_block got=%b want=1", blk4); end
  endtask

  task automatic test_sticky_clear();
    do_reset();
    deadlock_inputs();
    step(); step();
    quiet();
    step();
    total++; if (blk1 !== 1'b0) begin bad++; $display("FAIL clr_block_fall got=%b want=0", blk1); end
    total++; if (stk1 !== 1'b1) begin bad++; $display("FAIL clr_sticky_hold got=%b want=1", stk1); end
    total++; if (vec1 !== 5'b00001) begin bad++; $display("FAIL clr_vec_hold got=%b want=00001", vec1); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++; if (stk1 !== 1'b0) begin bad++; $display("FAIL clr_sticky got=%b want=0", stk1); end
    total++; if (vec1 !== 5'b0) begin bad++; $display("FAIL clr_vec got=%b want=00000", vec1); end
    deadlock_inputs();
    clear = 1'b1;
    step();
    total++; if (stk1 !== 1'b1) begin bad++; $display("FAIL clr_race_sticky got=%b want=1", stk1); end
    total++; if (vec1 !== 5'b00001) begin bad++; $display("FAIL clr_race_vec got=%b want=00001", vec1); end
    step();
    clear = 1'b0;
    total++; if (stk1 !== 1'b1) begin bad++; $display("FAIL clr_persist_sticky got=%b want=1", stk1); end
    total++; if (blk1 !== 1'b1) begin bad++; $display("FAIL clr_persist_block got=%b want=1", blk1); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    deadlock_inputs();
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (sc3 !== 3'((k > 7) ? 7 : k)) begin
        bad++; $display("FAIL sat_stall cyc=%0d got=%0d want=%0d", k, sc3, (k > 7) ? 7 : k);
      end
    end
    total++; if (sc1 !== 8'd10) begin bad++; $display("FAIL sat_wide_stall got=%0d want=10", sc1); end
    total++; if (blk3 !== 1'b1) begin bad++; $display("FAIL sat_block got=%b want=1", blk3); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (blk3 !== 1'b0) begin bad++; $display("FAIL rst_mid_block got=%b want=0", blk3); end
    total++; if (stk3 !== 1'b0) begin bad++; $display("FAIL rst_mid_sticky got=%b want=0", stk3); end
    total++; if (vec3 !== 5'b0) begin bad++; $display("FAIL rst_mid_vec got=%b want=00000", vec3); end
    total++; if (sc3 !== 3'd0) begin bad++; $display("FAIL rst_mid_stall got=%0d want=0", sc3); end
    total++; if (blk4 !== 1'b0) begin bad++; $display("FAIL rst_mid_thr4 got=%b want=0", blk4); end
    step();
    total++; if (blk3 !== 1'b1) begin bad++; $display("FAIL rst_release_block got=%b want=1", blk3); end
    quiet();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_axis();
    test_threshold();
    test_sub_gating();
    test_sticky_clear();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hls_deadlock_monitor_gen.md
Name: hls_deadlock_monitor_gen

Overview:
- Parametrised successor to the per-dataflow-region HLS deadlock monitors.
- Watches NUM_PROC dataflow processes and NUM_AXIS AXI-Stream block signals, and flags deadlock when every process is stopped and at least one is AXIS-blocked.
- Adds a configurable process-to-AXIS mapping, a persistence threshold, a sticky flag with clear, capture of the offending process vector, and a stall counter.
- Sits inside the kernel's deadlock-detection tree. Child-region monitor outputs feed in through sub_block.

Parameters:
NUM_PROC, 5, number of dataflow processes monitored (1..32)
NUM_AXIS, 3, number of AXIS block inputs (1..32)
AXIS_MAP, {NUM_PROC*NUM_AXIS{1'b0}}, bit [i*NUM_AXIS+j]=1 means AXIS j belongs to process i
CNT_W, 8, width of the threshold counter and stall counter
THRESHOLD, 1, consecutive condition cycles before block asserts (1..2^CNT_W-1)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
axis_block_sigs  in  NUM_AXIS  per-AXIS blocked indication
inst_idle_sigs  in  NUM_PROC  per-process idle
inst_block_sigs  in  NUM_PROC  per-process channel (FIFO/PIPO) block
sub_block  in  NUM_PROC  child-monitor qualifier per process; tie 1 where no child monitor exists
clear  in  1  one-cycle pulse that clears block_sticky and block_proc_vec
block  out  1  live deadlock flag
block_sticky  out  1  latched deadlock flag
block_proc_vec  out  NUM_PROC  AXIS-blocked processes captured on entry to BLOCKED
stall_cnt  out  CNT_W  consecutive cycles the condition has held, saturating

Behaviour:
- Combinational terms:
  - axis_blk[i] = sub_block[i] & |(axis_block_sigs & AXIS_MAP slice i). A zero slice forces axis_blk[i]=0.
  - stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | axis_blk[i].
  - cond = (|axis_blk) & (&stop).
- FSM states: IDLE, ARMED, BLOCKED. Internal counter cnt is CNT_W bits.
  - IDLE:
    - cond and THRESHOLD==1 -> BLOCKED.
    - cond and THRESHOLD>1 -> ARMED, cnt=1.
    - else stay, cnt=0.
  - ARMED:
    - !cond -> IDLE, cnt=0.
    - cond and cnt==THRESHOLD-1 -> BLOCKED.
    - cond otherwise -> cnt+1.
  - BLOCKED:
    - !cond -> IDLE, cnt=0.
    - else stay.
- block is registered: 1 exactly when state==BLOCKED.
  - Latency: block rises on the clock edge ending the THRESHOLD-th consecutive cond cycle.
  - block falls on the edge ending the first !cond cycle.
  - With THRESHOLD=1 this is a one-cycle registered version of cond.
- block_sticky:
  - Set on any cycle where next state is BLOCKED.
  - Cleared by clear only.
  - Set has priority over clear in the same cycle, so an event is never lost. While a deadlock persists, clear has no visible effect.
- block_proc_vec:
  - Loaded with axis_blk on the IDLE/ARMED->BLOCKED transition only.
  - Held until the next entry to BLOCKED or until clear.
  - On simultaneous load and clear, the load wins.
- stall_cnt:
  - 0 when !cond.
  - Otherwise increments each cond cycle, saturating at 2^CNT_W-1 with no wrap.
  - Independent of the FSM.
- Reset:
  - All outputs 0, state IDLE, cnt 0 on the cycle after reset is sampled high, including mid-ARMED or mid-BLOCKED.
  - Inputs are ignored while reset is high.
- X-free: all registers are reset; no combinational path from inputs to outputs.

Test Plan:
- Basic: NUM_PROC=5, THRESHOLD=1, AXIS_MAP maps AXIS0->proc0, AXIS1/2->proc3. Procs 1-4 idle, axis_block_sigs=3'b001, sub_block=5'b11111 -> block=1 one cycle later, block_proc_vec=5'b00001, block_sticky=1.
- No AXIS block: all five processes chan-blocked, axis_block_sigs=0 -> block stays 0, stall_cnt stays 0.
- Threshold: THRESHOLD=4, cond held 3 cycles then dropped -> block never rises. Cond then held 4 cycles -> block=1 on the 4th edge, stall_cnt=4 at that edge.
- Sub-gating: sub_block[3]=0, axis_block_sigs=3'b110, proc3 not idle or chan-blocked -> cond=0, block=0. Raise sub_block[3] -> block=1 after THRESHOLD cycles.
- Sticky and clear: deadlock for 2 cycles, then cond dropped -> block=0, block_sticky=1. Pulse clear -> block_sticky=0, block_proc_vec=0. Pulse clear in the same cycle as BLOCKED entry -> block_sticky=1.
- Reset and saturation: CNT_W=3, hold cond 10 cycles -> stall_cnt saturates at 7. Assert reset mid-BLOCKED -> next cycle block, block_sticky, block_proc_vec and stall_cnt are all 0.
